dummy_pulpino_read: RTL and testbench

Host-to-core counterpart of the Pulpino byte writer. It consumes bytes that the USB side posts through `usb_pulpino_channel` (USB → Pulpino direction) and assembles each group of four into a 32-bit word. It presents each word on a word-level toggle ("flicker") handshake to the Pulpino-side consumer. It connects to the channel's `usb_to_pulpino_data`, `usb_write_flicker` and `pulpino_read_flicker` ports.

---
 rtl/pulpino_usb_pkg.sv | 21 ++
 rtl/flicker_event_detect.sv | 22 ++
 rtl/dummy_pulpino_read.sv | 119 +++++++++++
 tb/tb_dummy_pulpino_read.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pulpino_usb_pkg.sv
// Shared types and constants for the USB <-> Pulpino byte/word movers.
// Both the read and the write side build on the same word geometry.
package pulpino_usb_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PUBLISH,
    WAIT_ACK
  } rd_state_t;

  // Byte lane inside a word for the idx-th received byte.
  function automatic logic [1:0] byte_lane(input logic msb_first, input logic [1:0] idx);
    return msb_first ? (2'(BYTES_PER_WORD - 1) - idx) : idx;
  endfunction

endpackage

// File: rtl/flicker_event_detect.sv
// Toggle-handshake receiver: an event is pending while the input flicker
// differs from its shadow; consume (or resync) copies the flicker into the shadow.
module flicker_event_detect (
  input  logic clk,
  input  logic resync_i,
  input  logic flicker_i,
  input  logic consume_i,
  output logic pending_o
);

  logic shadow_q;

  // Resync on reset swallows whatever toggle is outstanding at that moment.
  always_ff @(posedge clk) begin
    if (resync_i || consume_i) begin
      shadow_q <= flicker_i;
    end
  end

  assign pending_o = (flicker_i != shadow_q);

endmodule

// File: rtl/dummy_pulpino_read.sv
// Assembles four channel bytes into a 32-bit word and hands each word to the
// Pulpino side over a toggle handshake.
//
//   state    | meaning
//   IDLE     | waiting for enable to start a new word
//   COLLECT  | consuming bytes into the assembly register
//   PUBLISH  | copying the assembled word out, toggling the word flicker
//   WAIT_ACK | holding the word until the consumer toggles its ack
module dummy_pulpino_read
  import pulpino_usb_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              enable,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              did_byte_write_flicker,
  output logic              did_byte_read_flicker,
  output logic [WORD_W-1:0] out_word,
  output logic              did_word_write_flicker,
  input  logic              did_word_read_flicker,
  output logic              busy
);

  rd_state_t         state_q, state_d;
  logic [1:0]        count_q, count_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] out_word_q, out_word_d;
  logic              byte_ack_q, byte_ack_d;
  logic              word_flk_q, word_flk_d;
  logic              byte_pending, byte_consume;
  logic              ack_pending;
  logic [1:0]        lane;

  flicker_event_detect u_byte_evt (
    .clk       (clk),
    .resync_i  (reset_i),
    .flicker_i (did_byte_write_flicker),
    .consume_i (byte_consume),
    .pending_o (byte_pending)
  );

  // Ack shadow follows every cycle, so toggles outside WAIT_ACK are lost.
  flicker_event_detect u_ack_evt (
    .clk       (clk),
    .resync_i  (reset_i),
    .flicker_i (did_word_read_flicker),
    .consume_i (1'b1),
    .pending_o (ack_pending)
  );

  assign lane = byte_lane(MSB_FIRST, count_q);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    asm_d        = asm_q;
    out_word_d   = out_word_q;
    byte_ack_d   = byte_ack_q;
    word_flk_d   = word_flk_q;
    byte_consume = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = COLLECT;
          count_d = 2'd0;
          asm_d   = '0;
        end
      end
      COLLECT: begin
        if (byte_pending) begin
          asm_d[lane*BYTE_W +: BYTE_W] = in_data;
          byte_ack_d   = ~byte_ack_q;
          byte_consume = 1'b1;
          count_d      = count_q + 2'd1;
          if (count_q == 2'(BYTES_PER_WORD - 1)) begin
            state_d = PUBLISH;
          end
        end
      end
      PUBLISH: begin
        out_word_d = asm_q;
        word_flk_d = ~word_flk_q;
        state_d    = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_pending) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q    <= IDLE;
      count_q    <= 2'd0;
      asm_q      <= '0;
      out_word_q <= '0;
      byte_ack_q <= 1'b0;
      word_flk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      asm_q      <= asm_d;
      out_word_q <= out_word_d;
      byte_ack_q <= byte_ack_d;
      word_flk_q <= word_flk_d;
    end
  end

  assign out_word               = out_word_q;
  assign did_byte_read_flicker  = byte_ack_q;
  assign did_word_write_flicker = word_flk_q;
  assign busy                   = (state_q != IDLE);

endmodule

// File: tb/tb_dummy_pulpino_read.sv
// Bench for dummy_pulpino_read: one MSB-first and one LSB-first instance share
// the same stimulus; expected words come from the posted bytes directly.
module tb_dummy_pulpino_read;

  logic        clk = 1'b0;
  logic        reset_i, enable;
  logic [7:0]  in_data;
  logic        bwf, wrf;
  logic        brf_m, wwf_m, busy_m;
  logic        brf_l, wwf_l, busy_l;
  logic [31:0] ow_m, ow_l;

  always #5 clk = ~clk;

  dummy_pulpino_read #(.MSB_FIRST(1'b1)) dut_m (
    .clk                    (clk),
    .reset_i                (reset_i),
    .enable                 (enable),
    .in_data                (in_data),
    .did_byte_write_flicker (bwf),
    .did_byte_read_flicker  (brf_m),
    .out_word               (ow_m),
    .did_word_write_flicker (wwf_m),
    .did_word_read_flicker  (wrf),
    .busy                   (busy_m)
  );

  dummy_pulpino_read #(.MSB_FIRST(1'b0)) dut_l (
    .clk                    (clk),
    .reset_i                (reset_i),
    .enable                 (enable),
    .in_data                (in_data),
    .did_byte_write_flicker (bwf),
    .did_byte_read_flicker  (brf_l),
    .out_word               (ow_l),
    .did_word_write_flicker (wwf_l),
    .did_word_read_flicker  (wrf),
    .busy                   (busy_l)
  );

  int          checks = 0;
  int          errors = 0;
  logic        exp_brf, exp_wwf;
  logic [31:0] exp_ow_m, exp_ow_l;
  logic [7:0]  wb [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference word: first posted byte is the most (or least) significant.
  function automatic logic [31:0] word_of(input logic msb);
    return msb ? {wb[0], wb[1], wb[2], wb[3]} : {wb[3], wb[2], wb[1], wb[0]};
  endfunction

  task automatic check_all(input string tag, input logic exp_busy);
    check({tag, "_word_m"}, ow_m, exp_ow_m);
    check({tag, "_word_l"}, ow_l, exp_ow_l);
    check({tag, "_brf_m"}, 32'(brf_m), 32'(exp_brf));
    check({tag, "_brf_l"}, 32'(brf_l), 32'(exp_brf));
    check({tag, "_wwf_m"}, 32'(wwf_m), 32'(exp_wwf));
    check({tag, "_wwf_l"}, 32'(wwf_l), 32'(exp_wwf));
    check({tag, "_busy_m"}, 32'(busy_m), 32'(exp_busy));
    check({tag, "_busy_l"}, 32'(busy_l), 32'(exp_busy));
  endtask

  task automatic post_byte(input logic [7:0] b);
    in_data = b;
    bwf     = ~bwf;
  endtask

  task automatic wait_byte_ack(input string tag);
    for (int i = 0; i < 20 && brf_m === exp_brf; i++) tick();
    exp_brf = ~exp_brf;
    check({tag, "_ack_m"}, 32'(brf_m), 32'(exp_brf));
    check({tag, "_ack_l"}, 32'(brf_l), 32'(exp_brf));
  endtask

  task automatic rand_word();
    for (int i = 0; i < 4; i++) wb[i] = 8'($urandom_range(0, 255));
  endtask

  // Posts wb[start..3] with random gaps, then checks the publish one cycle later.
  task automatic send_rest(input int start, input bit drop_enable);
    for (int i = start; i < 4; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (drop_enable && i == 2) enable = 1'b0;
      post_byte(wb[i]);
      wait_byte_ack("byte");
    end
    check("pre_publish_wwf_m", 32'(wwf_m), 32'(exp_wwf));
    tick();
    exp_wwf  = ~exp_wwf;
    exp_ow_m = word_of(1'b1);
    exp_ow_l = word_of(1'b0);
    check_all("publish", 1'b1);
  endtask

  task automatic ack_word();
    repeat ($urandom_range(0, 3)) tick();
    check_all("hold", 1'b1);
    wrf = ~wrf;
    tick();
    check_all("ack", 1'b0);
  endtask

  initial begin
    reset_i = 1'b1;
    enable  = 1'b0;
    in_data = 8'h00;
    bwf     = 1'b0;
    wrf     = 1'b0;
    exp_brf = 1'b0;
    exp_wwf = 1'b0;
    exp_ow_m = '0;
    exp_ow_l = '0;
    tick();
    tick();
    reset_i = 1'b0;
    tick();
    check_all("reset", 1'b0);

    // Known bytes, both byte orders.
    wb[0] = 8'h12; wb[1] = 8'h34; wb[2] = 8'hAB; wb[3] = 8'hCD;
    enable = 1'b1;
    send_rest(0, 1'b0);
    check("known_msb", ow_m, 32'h1234ABCD);
    check("known_lsb", ow_l, 32'hCDAB3412);
    ack_word();

    // Byte arriving in WAIT_ACK stays pending until the ack.
    rand_word();
    send_rest(0, 1'b0);
    post_byte(8'h55);
    repeat (5) tick();
    check_all("wait_pending", 1'b1);
    wrf = ~wrf;
    tick();
    check_all("ack_with_pending", 1'b0);
    rand_word();
    wb[0] = 8'h55;
    wait_byte_ack("pending_consumed");
    send_rest(1, 1'b0);
    ack_word();

    // Enable dropped mid-word: word still completes, then block stays idle.
    rand_word();
    send_rest(0, 1'b1);
    ack_word();
    repeat (4) tick();
    check_all("idle_after_drop", 1'b0);

    // Word acks outside WAIT_ACK are ignored.
    wrf = ~wrf;
    repeat (3) tick();
    check_all("ack_in_idle", 1'b0);
    enable = 1'b1;
    rand_word();
    post_byte(wb[0]);
    wait_byte_ack("collect_b0");
    wrf = ~wrf;
    repeat (2) tick();
    check_all("ack_in_collect", 1'b1);
    send_rest(1, 1'b0);
    ack_word();

    // Reset after three bytes with both input flickers high.
    rand_word();
    for (int i = 0; i < 3; i++) begin
      post_byte(wb[i]);
      wait_byte_ack("pre_reset");
    end
    reset_i = 1'b1;
    enable  = 1'b0;
    bwf     = 1'b1;
    wrf     = 1'b1;
    tick();
    tick();
    reset_i  = 1'b0;
    exp_brf  = 1'b0;
    exp_wwf  = 1'b0;
    exp_ow_m = '0;
    exp_ow_l = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all("post_reset", 1'b0);
    end
    enable = 1'b1;
    rand_word();
    send_rest(0, 1'b0);
    ack_word();

    // Random words, occasionally dropping enable mid-word.
    for (int w = 0; w < 8; w++) begin
      enable = 1'b1;
      rand_word();
      send_rest(0, 1'($urandom_range(0, 1)));
      ack_word();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
